// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One access in flight; load hits finish combinationally, misses fill a 64-bit block.
//
// state     | meaning
// IDLE      | accept a new access; load hit completes here
// MISS_REQ  | issue block read, retry until memory accepts
// MISS_WAIT | wait for the accepted tag, fill line and finish
// ST_REQ    | issue write-through store, retry until accepted
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int XLEN      = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      proc2Dcache_command,
   input  logic [XLEN-1:0] proc2Dcache_addr,
   input  logic [1:0]      proc2Dcache_size,
   input  logic [XLEN-1:0] proc2Dcache_data,
   output logic [XLEN-1:0] Dcache2proc_data,
   output logic            Dcache2proc_finish,
   output logic [1:0]      proc2mem_command,
   output logic [XLEN-1:0] proc2mem_addr,
   output logic [63:0]     proc2mem_data,
   output logic [1:0]      proc2mem_size,
   input  logic [3:0]      mem2proc_response,
   input  logic [63:0]     mem2proc_data,
   input  logic [3:0]      mem2proc_tag
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = XLEN - 3 - IDX_W;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   localparam logic [1:0] SZ_BYTE   = 2'd0;
   localparam logic [1:0] SZ_HALF   = 2'd1;
   localparam logic [1:0] SZ_DOUBLE = 2'd3;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] MISS_REQ  = 2'd1;
   localparam logic [1:0] MISS_WAIT = 2'd2;
   localparam logic [1:0] ST_REQ    = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [3:0]           mem_tag_q, mem_tag_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     line_tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     line_tag_d  [NUM_LINES];
   logic [63:0]          line_data_q [NUM_LINES];
   logic [63:0]          line_data_d [NUM_LINES];

   logic [2:0]       addr_off;
   logic [IDX_W-1:0] addr_idx;
   logic [TAG_W-1:0] addr_tag;
   logic             hit;

   assign addr_off = proc2Dcache_addr[2:0];
   assign addr_idx = proc2Dcache_addr[3+IDX_W-1:3];
   assign addr_tag = proc2Dcache_addr[XLEN-1:3+IDX_W];
   assign hit      = valid_q[addr_idx] && (line_tag_q[addr_idx] == addr_tag);

   function automatic logic [31:0] extract(input logic [63:0] blk, input logic [2:0] off,
                                           input logic [1:0] size);
      logic [63:0] sh;
      sh = blk >> {off, 3'b000};
      case (size)
         SZ_BYTE: extract = {24'b0, sh[7:0]};
         SZ_HALF: extract = {16'b0, sh[15:0]};
         default: extract = sh[31:0];
      endcase
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [31:0] wr,
                                         input logic [2:0] off, input logic [1:0] size);
      logic [63:0] mask;
      logic [63:0] wd;
      case (size)
         SZ_BYTE: mask = 64'h0000_0000_0000_00FF;
         SZ_HALF: mask = 64'h0000_0000_0000_FFFF;
         default: mask = 64'h0000_0000_FFFF_FFFF;
      endcase
      mask  = mask << {off, 3'b000};
      wd    = {32'b0, wr} << {off, 3'b000};
      merge = (old & ~mask) | (wd & mask);
   endfunction

   always_comb begin
      state_d            = state_q;
      mem_tag_d          = mem_tag_q;
      valid_d            = valid_q;
      line_tag_d         = line_tag_q;
      line_data_d        = line_data_q;
      Dcache2proc_data   = '0;
      Dcache2proc_finish = 1'b0;
      proc2mem_command   = BUS_NONE;
      proc2mem_addr      = '0;
      proc2mem_data      = '0;
      proc2mem_size      = SZ_BYTE;
      case (state_q)
         IDLE: begin
            if (proc2Dcache_command == BUS_LOAD) begin
               if (hit) begin
                  Dcache2proc_finish = 1'b1;
                  Dcache2proc_data   = extract(line_data_q[addr_idx], addr_off, proc2Dcache_size);
               end else begin
                  state_d = MISS_REQ;
               end
            end else if (proc2Dcache_command == BUS_STORE) begin
               state_d = ST_REQ;
            end
         end
         MISS_REQ: begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = {proc2Dcache_addr[XLEN-1:3], 3'b000};
            proc2mem_size    = SZ_DOUBLE;
            if (mem2proc_response != 4'd0) begin
               mem_tag_d = mem2proc_response;
               state_d   = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if ((mem2proc_tag != 4'd0) && (mem2proc_tag == mem_tag_q)) begin
               valid_d[addr_idx]     = 1'b1;
               line_tag_d[addr_idx]  = addr_tag;
               line_data_d[addr_idx] = mem2proc_data;
               Dcache2proc_finish    = 1'b1;
               Dcache2proc_data      = extract(mem2proc_data, addr_off, proc2Dcache_size);
               state_d               = IDLE;
            end
         end
         default: begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = proc2Dcache_addr;
            proc2mem_size    = proc2Dcache_size;
            proc2mem_data    = {32'b0, proc2Dcache_data};
            if (mem2proc_response != 4'd0) begin
               Dcache2proc_finish = 1'b1;
               if (hit)
                  line_data_d[addr_idx] = merge(line_data_q[addr_idx], proc2Dcache_data,
                                                addr_off, proc2Dcache_size);
               state_d = IDLE;
            end
         end
      endcase
      // Reset abandons any access in flight: no finish or bus activity in that cycle.
      if (reset) begin
         Dcache2proc_data   = '0;
         Dcache2proc_finish = 1'b0;
         proc2mem_command   = BUS_NONE;
         proc2mem_addr      = '0;
         proc2mem_data      = '0;
         proc2mem_size      = SZ_BYTE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         mem_tag_q <= 4'd0;
         valid_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_tag_q   <= mem_tag_d;
         valid_q     <= valid_d;
         line_tag_q  <= line_tag_d;
         line_data_q <= line_data_d;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl at NUM_LINES=8: miss fill, hits, write-through
// stores with retry, line replacement and reset abandoning an outstanding miss.
module tb_dcache_ctrl;
   localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
   localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  p_cmd;
   logic [31:0] p_addr;
   logic [1:0]  p_size;
   logic [31:0] p_data;
   logic [31:0] d_data;
   logic        d_fin;
   logic [1:0]  m_cmd;
   logic [31:0] m_addr;
   logic [63:0] m_data;
   logic [1:0]  m_size;
   logic [3:0]  m_resp;
   logic [63:0] m_rdata;
   logic [3:0]  m_tag;

   int n_cmp = 0;
   int n_err = 0;
   int st_cnt;

   dcache_ctrl #(.NUM_LINES(8)) dut (
      .clock(clock), .reset(reset),
      .proc2Dcache_command(p_cmd), .proc2Dcache_addr(p_addr),
      .proc2Dcache_size(p_size), .proc2Dcache_data(p_data),
      .Dcache2proc_data(d_data), .Dcache2proc_finish(d_fin),
      .proc2mem_command(m_cmd), .proc2mem_addr(m_addr),
      .proc2mem_data(m_data), .proc2mem_size(m_size),
      .mem2proc_response(m_resp), .mem2proc_data(m_rdata), .mem2proc_tag(m_tag)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic [1:0] c, input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d);
      p_cmd = c; p_addr = a; p_size = s; p_data = d;
   endtask

   task automatic mem(input logic [3:0] r, input logic [3:0] t, input logic [63:0] d);
      m_resp = r; m_tag = t; m_rdata = d;
   endtask

   initial begin
      reset = 1'b1;
      req(NONE, 0, BYTE, 0);
      mem(0, 0, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst finish", d_fin, 0);
      chk("rst mem_cmd", m_cmd, NONE);
      chk("rst mem_addr", m_addr, 0);
      chk("rst mem_data", m_data, 0);
      chk("rst load_data", d_data, 0);

      // cold load miss; tag in the acceptance cycle must be ignored
      cyc(); req(LOAD, 32'h100, WORD, 0);
      @(negedge clock);
      chk("t1 miss finish", d_fin, 0);
      chk("t1 idle mem_cmd", m_cmd, NONE);
      cyc(); mem(3, 3, 64'h11223344_AABBCCDD);
      @(negedge clock);
      chk("t1 missreq cmd", m_cmd, LOAD);
      chk("t1 missreq addr", m_addr, 32'h100);
      chk("t1 missreq size", m_size, 2'd3);
      chk("t1 accept-cycle tag ignored", d_fin, 0);
      cyc(); mem(0, 0, 0);
      @(negedge clock);
      chk("t1 wait cmd", m_cmd, NONE);
      chk("t1 wait finish", d_fin, 0);
      cyc(); mem(0, 3, 64'h11223344_AABBCCDD);
      @(negedge clock);
      chk("t1 fill finish", d_fin, 1);
      chk("t1 fill data", d_data, 32'hAABBCCDD);

      // byte hit on the filled line
      cyc(); mem(0, 0, 0); req(LOAD, 32'h105, BYTE, 0);
      @(negedge clock);
      chk("t2 hit finish", d_fin, 1);
      chk("t2 hit data", d_data, 32'h33);
      chk("t2 hit mem_cmd", m_cmd, NONE);

      // store half with two rejected attempts
      cyc(); req(STORE, 32'h102, HALF, 32'hBEEF);
      @(negedge clock);
      chk("t3 idle finish", d_fin, 0);
      st_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(); mem((i == 2) ? 4'd5 : 4'd0, 0, 0);
         @(negedge clock);
         if (m_cmd == STORE) st_cnt++;
         chk("t3 st addr", m_addr, 32'h102);
         chk("t3 st size", m_size, HALF);
         chk("t3 st data", m_data, 64'hBEEF);
         chk("t3 st finish", d_fin, (i == 2) ? 1 : 0);
      end
      chk("t3 store cycles", st_cnt, 3);
      cyc(); mem(0, 0, 0); req(LOAD, 32'h100, WORD, 0);
      @(negedge clock);
      chk("t3 merged finish", d_fin, 1);
      chk("t3 merged data", d_data, 32'hBEEFCCDD);

      // store to an unmapped address: write-through only
      cyc(); req(STORE, 32'h2000, WORD, 32'h12345678);
      @(negedge clock);
      cyc(); mem(1, 0, 0);
      @(negedge clock);
      chk("t4 st cmd", m_cmd, STORE);
      chk("t4 st addr", m_addr, 32'h2000);
      chk("t4 st data", m_data, 64'h12345678);
      chk("t4 st finish", d_fin, 1);
      cyc(); mem(0, 0, 0); req(LOAD, 32'h100, WORD, 0);
      @(negedge clock);
      chk("t4 line untouched", d_data, 32'hBEEFCCDD);
      cyc(); req(LOAD, 32'h2000, WORD, 0);
      @(negedge clock);
      chk("t4 no allocate", d_fin, 0);
      cyc(); mem(2, 0, 0);
      @(negedge clock);
      chk("t4 missreq cmd", m_cmd, LOAD);
      chk("t4 missreq addr", m_addr, 32'h2000);
      cyc(); mem(0, 2, 64'hCAFEF00D_87654321);
      @(negedge clock);
      chk("t4 fill finish", d_fin, 1);
      chk("t4 fill data", d_data, 32'h87654321);

      // conflicting index replaces the line
      cyc(); mem(0, 0, 0); req(LOAD, 32'h140, WORD, 0);
      @(negedge clock);
      chk("t5 conflict miss", d_fin, 0);
      cyc(); mem(4, 0, 0);
      @(negedge clock);
      chk("t5 missreq addr", m_addr, 32'h140);
      cyc(); mem(0, 4, 64'h55667788_99AABBCC);
      @(negedge clock);
      chk("t5 fill data", d_data, 32'h99AABBCC);
      cyc(); mem(0, 0, 0); req(LOAD, 32'h146, HALF, 0);
      @(negedge clock);
      chk("t5 half hit finish", d_fin, 1);
      chk("t5 half hit data", d_data, 32'h5566);
      cyc(); req(LOAD, 32'h100, WORD, 0);
      @(negedge clock);
      chk("t5 evicted miss", d_fin, 0);
      cyc(); mem(6, 0, 0);
      @(negedge clock);
      chk("t5 missreq cmd", m_cmd, LOAD);
      chk("t5 missreq addr", m_addr, 32'h100);

      // reset while waiting for the fill
      cyc(); mem(0, 0, 0);
      @(negedge clock);
      chk("t6 wait finish", d_fin, 0);
      cyc(); reset = 1'b1; mem(0, 6, 64'hDEADBEEF_DEADBEEF);
      @(negedge clock);
      chk("t6 reset-cycle finish", d_fin, 0);
      cyc(); reset = 1'b0; req(NONE, 0, BYTE, 0);
      @(negedge clock);
      chk("t6 late tag finish", d_fin, 0);
      chk("t6 idle mem_cmd", m_cmd, NONE);
      chk("t6 idle load_data", d_data, 0);
      cyc(); mem(0, 0, 0); req(LOAD, 32'h140, WORD, 0);
      @(negedge clock);
      chk("t6 line invalid", d_fin, 0);
      cyc();
      @(negedge clock);
      chk("t6 from idle to missreq", m_cmd, LOAD);
      chk("t6 missreq addr", m_addr, 32'h140);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
